// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - shared CPU widths plus writeback arbiter state and request types
package riscv_cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ARB_EMPTY,
        ARB_PENDING,
        ARB_FORCE
    } wb_arb_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// rtl/wb_arb_fifo.sv - synchronous FIFO buffering multicycle writeback requests
module wb_arb_fifo
    import riscv_cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_req_t                    push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output wb_req_t                    head
);

    localparam int AW = $clog2(DEPTH);

    // The extra pointer MSB separates full from empty when the indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_req_t     mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbiter between pipeline writeback and multicycle results
module wb_arbiter
    import riscv_cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = riscv_cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = riscv_cpu_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            wb_we_i,
    input  logic [ADDR_WIDTH-1:0]           wb_dest_reg_i,
    input  logic [DATA_WIDTH-1:0]           wb_wdata_i,
    output logic                            wb_stall_o,
    input  logic                            mc_valid_i,
    output logic                            mc_ready_o,
    input  logic [ADDR_WIDTH-1:0]           mc_dest_reg_i,
    input  logic [DATA_WIDTH-1:0]           mc_wdata_i,
    output logic                            rf_we_o,
    output logic [ADDR_WIDTH-1:0]           rf_waddr_o,
    output logic [DATA_WIDTH-1:0]           rf_wdata_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] pend_cnt_o
);

    localparam int CW    = $clog2(FIFO_DEPTH+1);
    localparam int AGE_W = $clog2(STARVE_LIMIT+1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    wb_arb_state_e    state_q;
    wb_arb_state_e    state_n;
    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_n;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             full;
    logic             empty;
    wb_req_t          head;
    wb_req_t          mc_req;
    logic             wb_req;
    logic             conflict;
    logic             head_grant;
    logic             wb_grant;
    logic             push;

    assign wb_req   = wb_we_i && (wb_dest_reg_i != '0);
    assign conflict = wb_req && (wb_dest_reg_i == head.dest);

    // A queued result to the same register is older, so it must land first.
    assign head_grant = (state_q != ARB_EMPTY) &&
                        (!wb_req || conflict || (state_q == ARB_FORCE));
    assign wb_grant   = wb_req && !head_grant;
    assign wb_stall_o = wb_req && head_grant;

    assign mc_ready_o = !full;
    assign push       = mc_valid_i && !full && (mc_dest_reg_i != '0);
    assign pend_cnt_o = count;
    assign mc_req     = '{dest: mc_dest_reg_i, data: mc_wdata_i};

    wb_arb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (mc_req),
        .pop       (head_grant),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        count_n = count + CW'(push) - CW'(head_grant);
        age_n   = age_q;
        if (head_grant || empty) begin
            age_n = '0;
        end else if (age_q != AGE_MAX) begin
            age_n = age_q + 1'b1;
        end
        state_n = ARB_PENDING;
        if (count_n == '0) begin
            state_n = ARB_EMPTY;
        end else if (age_n == AGE_MAX) begin
            state_n = ARB_FORCE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_EMPTY;
            age_q      <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            state_q <= state_n;
            age_q   <= age_n;
            rf_we_o <= head_grant || wb_grant;
            if (head_grant) begin
                rf_waddr_o <= head.dest;
                rf_wdata_o <= head.data;
            end else if (wb_grant) begin
                rf_waddr_o <= wb_dest_reg_i;
                rf_wdata_o <= wb_wdata_i;
            end else begin
                rf_waddr_o <= '0;
                rf_wdata_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_wdata;
    logic        wb_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_dest;
    logic [31:0] mc_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  pend_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_stall;
    int pi;
    logic [36:0] wlog[$];

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (5),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wb_we_i       (wb_we),
        .wb_dest_reg_i (wb_dest),
        .wb_wdata_i    (wb_wdata),
        .wb_stall_o    (wb_stall),
        .mc_valid_i    (mc_valid),
        .mc_ready_o    (mc_ready),
        .mc_dest_reg_i (mc_dest),
        .mc_wdata_i    (mc_wdata),
        .rf_we_o       (rf_we),
        .rf_waddr_o    (rf_waddr),
        .rf_wdata_o    (rf_wdata),
        .pend_cnt_o    (pend_cnt)
    );

    always @(negedge clk) begin
        if (rf_we === 1'b1) wlog.push_back({rf_waddr, rf_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                         input logic mv, input logic [4:0] md, input logic [31:0] mdat);
        wb_we    = we;
        wb_dest  = wd;
        wb_wdata = wdat;
        mc_valid = mv;
        mc_dest  = md;
        mc_wdata = mdat;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [4:0] a, input logic [31:0] d);
        logic [63:0] o;
        o = (idx < wlog.size()) ? 64'(wlog[idx]) : '1;
        chk(tag, o, {27'b0, a, d});
    endtask

    initial begin
        rst = 1'b1;
        wb_we = 0; wb_dest = 0; wb_wdata = 0; mc_valid = 0; mc_dest = 0; mc_wdata = 0;
        tick();
        tick();
        rst = 1'b0;
        idle();
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_waddr", rf_waddr, 5'd0);
        chk("reset_wdata", rf_wdata, 32'h0);
        chk("reset_stall", wb_stall, 1'b0);
        chk("reset_ready", mc_ready, 1'b1);
        chk("reset_pend", pend_cnt, 2'd0);

        // idle pipeline: x7 pushed in cycle 0, written in cycle 2
        tick();
        wlog.delete();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF);
        chk("idle_ready_c0", mc_ready, 1'b1);
        tick(); idle();
        chk("idle_pend_c1", pend_cnt, 2'd1);
        chk("idle_we_c1", rf_we, 1'b0);
        tick(); idle();
        chk("idle_we_c2", rf_we, 1'b1);
        chk("idle_waddr_c2", rf_waddr, 5'd7);
        chk("idle_wdata_c2", rf_wdata, 32'hDEADBEEF);
        chk("idle_pend_c2", pend_cnt, 2'd0);
        tick(); idle();
        chk("idle_we_c3", rf_we, 1'b0);
        chk("idle_log_n", wlog.size(), 1);

        // starvation: pipeline writes every cycle, x3 forced after 4 waits
        tick();
        wlog.delete();
        pi = 0;
        n_stall = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 5'(10 + pi), 32'h100 + 32'(pi), c == 0, 5'd3, 32'h11);
            chk($sformatf("starve_stall_c%0d", c), wb_stall, (c == 5));
            if (wb_stall === 1'b1) n_stall++;
            else pi++;
            tick();
        end
        idle();
        tick(); idle();
        tick(); idle();
        chk("starve_stall_count", n_stall, 1);
        chk("starve_log_n", wlog.size(), 8);
        for (int i = 0; i < 5; i++) chk_log($sformatf("starve_log%0d", i), i, 5'(10 + i), 32'h100 + 32'(i));
        chk_log("starve_log5_x3", 5, 5'd3, 32'h11);
        chk_log("starve_log6", 6, 5'd15, 32'h105);
        chk_log("starve_log7", 7, 5'd16, 32'h106);

        // full FIFO: x5, x6 fill it, x9 held until the forced pop frees a slot
        tick();
        wlog.delete();
        drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd5, 32'h55);
        chk("full_ready_c0", mc_ready, 1'b1);
        tick();
        drive(1'b1, 5'd21, 32'h201, 1'b1, 5'd6, 32'h66);
        chk("full_ready_c1", mc_ready, 1'b1);
        tick();
        drive(1'b1, 5'd22, 32'h202, 1'b1, 5'd9, 32'h99);
        chk("full_ready_c2", mc_ready, 1'b0);
        chk("full_pend_c2", pend_cnt, 2'd2);
        tick();
        drive(1'b1, 5'd23, 32'h203, 1'b1, 5'd9, 32'h99);
        chk("full_ready_c3", mc_ready, 1'b0);
        tick();
        drive(1'b1, 5'd24, 32'h204, 1'b1, 5'd9, 32'h99);
        chk("full_stall_c4", wb_stall, 1'b0);
        tick();
        drive(1'b1, 5'd25, 32'h205, 1'b1, 5'd9, 32'h99);
        chk("full_stall_c5", wb_stall, 1'b1);
        chk("full_ready_c5", mc_ready, 1'b0);
        tick();
        drive(1'b1, 5'd25, 32'h205, 1'b1, 5'd9, 32'h99);
        chk("full_ready_c6", mc_ready, 1'b1);
        chk("full_stall_c6", wb_stall, 1'b0);
        tick(); idle();
        chk("full_pend_c7", pend_cnt, 2'd2);
        tick(); idle();
        tick(); idle();
        tick(); idle();
        chk("full_log_n", wlog.size(), 9);
        for (int i = 0; i < 5; i++) chk_log($sformatf("full_log%0d", i), i, 5'(20 + i), 32'h200 + 32'(i));
        chk_log("full_log_x5", 5, 5'd5, 32'h55);
        chk_log("full_log_p5", 6, 5'd25, 32'h205);
        chk_log("full_log_x6", 7, 5'd6, 32'h66);
        chk_log("full_log_x9", 8, 5'd9, 32'h99);

        // same-destination conflict on x4
        tick();
        wlog.delete();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hA);
        tick();
        drive(1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 32'h0);
        chk("conf_stall_c1", wb_stall, 1'b1);
        tick();
        drive(1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 32'h0);
        chk("conf_stall_c2", wb_stall, 1'b0);
        chk("conf_wdata_c2", rf_wdata, 32'hA);
        tick(); idle();
        chk("conf_waddr_c3", rf_waddr, 5'd4);
        chk("conf_wdata_c3", rf_wdata, 32'hB);
        tick(); idle();
        chk("conf_log_n", wlog.size(), 2);
        chk_log("conf_log_last", 1, 5'd4, 32'hB);

        // x0 filtering
        tick();
        wlog.delete();
        drive(1'b1, 5'd0, 32'h123, 1'b1, 5'd0, 32'h456);
        chk("x0_ready", mc_ready, 1'b1);
        chk("x0_stall", wb_stall, 1'b0);
        tick(); idle();
        chk("x0_pend", pend_cnt, 2'd0);
        chk("x0_we_c1", rf_we, 1'b0);
        tick(); idle();
        chk("x0_we_c2", rf_we, 1'b0);
        chk("x0_log_n", wlog.size(), 0);

        // reset with two entries pending
        tick();
        wlog.delete();
        drive(1'b1, 5'd30, 32'h300, 1'b1, 5'd1, 32'h1);
        tick();
        drive(1'b1, 5'd31, 32'h301, 1'b1, 5'd2, 32'h2);
        tick();
        rst = 1'b1;
        idle();
        chk("rstmid_pend_before", pend_cnt, 2'd2);
        tick();
        rst = 1'b0;
        idle();
        chk("rstmid_pend", pend_cnt, 2'd0);
        chk("rstmid_we", rf_we, 1'b0);
        chk("rstmid_ready", mc_ready, 1'b1);
        tick(); idle();
        tick(); idle();
        tick(); idle();
        chk("rstmid_log_n", wlog.size(), 2);
        chk_log("rstmid_log0", 0, 5'd30, 32'h300);
        chk_log("rstmid_log1", 1, 5'd31, 32'h301);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (wb_stage) and a long-latency multicycle unit (mul/div) that returns results out of band. Multicycle results are buffered in a small FIFO and inserted into idle write slots. A starvation counter forces a slot by stalling the pipeline. The block sits between wb_stage / multicycle unit and the register file write port; its outputs are registered.

## Interface
- DATA_WIDTH, riscv_cpu_pkg::DATA_WIDTH (32), write data width
- ADDR_WIDTH, riscv_cpu_pkg::ADDR_WIDTH (5), register index width
- FIFO_DEPTH, 2, multicycle result buffer entries (power of two, >=2)
- STARVE_LIMIT, 4, cycles the FIFO head may wait before forcing a slot (>=1)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- wb_we_i  in  1  pipeline write request
- wb_dest_reg_i  in  ADDR_WIDTH  pipeline destination register
- wb_wdata_i  in  DATA_WIDTH  pipeline write data
- wb_stall_o  out  1  pipeline request not granted this cycle; wb_stage holds its request
- mc_valid_i  in  1  multicycle result valid
- mc_ready_o  out  1  arbiter accepts result
- mc_dest_reg_i  in  ADDR_WIDTH  multicycle destination
- mc_wdata_i  in  DATA_WIDTH  multicycle result
- rf_we_o  out  1  register file write enable (registered)
- rf_waddr_o  out  ADDR_WIDTH  register file write address (registered)
- rf_wdata_o  out  DATA_WIDTH  register file write data (registered)
- pend_cnt_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy, for the hazard unit

## Operation
- Effective pipeline request: wb_req = wb_we_i && wb_dest_reg_i != 0.
- mc_ready_o = (count < FIFO_DEPTH), computed from the registered count. There is no full-bypass: a push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Handshake: a transfer occurs when mc_valid_i && mc_ready_o. A transfer with mc_dest_reg_i == 0 is acknowledged but not stored.
- States:
  - EMPTY: count 0.
  - PENDING: count > 0 and age < STARVE_LIMIT.
  - FORCE: count > 0 and age == STARVE_LIMIT.
- Grant rules:
  - EMPTY: pipeline granted.
  - PENDING: pipeline granted if wb_req. Otherwise the FIFO head is granted (popped).
  - FORCE: the FIFO head is granted.
  - Same-destination conflict: if wb_req and wb_dest_reg_i equals the head's destination, the head is granted in any non-EMPTY state. The older result is written first.
- wb_stall_o = wb_req && head granted.
- Age counter (saturating at STARVE_LIMIT):
  - Increments each cycle the FIFO is non-empty and the head is not granted.
  - Clears on pop and while EMPTY.
- Transitions:
  - EMPTY→PENDING on push.
  - PENDING→FORCE when age reaches STARVE_LIMIT.
  - FORCE→PENDING or EMPTY after the pop, depending on the remaining count.
  - Simultaneous push and pop leaves count unchanged.
- Reset: FIFO flushed (pending results discarded), age=0, state EMPTY. Next cycle: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, wb_stall_o=0, mc_ready_o=1, pend_cnt_o=0.

## Timing
- Grant in cycle t → rf_we_o, rf_waddr_o and rf_wdata_o valid in cycle t+1, for exactly one cycle.
- Pipeline: wb_req in cycle t with no stall → write at t+1.
- Multicycle: accepted at edge ending cycle t → head visible at t+1 → earliest write at t+2.
- Worst-case head wait with continuous pipeline writes: STARVE_LIMIT cycles, then a forced grant. With STARVE_LIMIT=4:
  - Head visible at t+1.
  - Pipeline writes t+1..t+4.
  - FORCE and wb_stall_o=1 at t+5.
  - Head written at t+6.
  - Stalled pipeline request written at t+7, provided no further FORCE.
- wb_stall_o is combinational from wb_we_i, wb_dest_reg_i and registered state.
- mc_ready_o and pend_cnt_o depend only on registered state.

## Structure
- riscv_cpu_pkg gains:
  - wb_arb_state_e enum: ARB_EMPTY, ARB_PENDING, ARB_FORCE.
  - wb_req_t struct: dest, data.
- Sub-module wb_arb_fifo: synchronous FIFO of wb_req_t.
  - Parameters: DEPTH.
  - Ports: push, pop, full, empty, count, head.
  - Wrap-around via a pointer MSB.
- Arbitration FSM, age counter and output registers live in wb_arbiter.

## Test plan
- Reset mid-operation: 2 entries pending, assert rst_i for 1 cycle → pend_cnt_o=0, rf_we_o=0, mc_ready_o=1 the next cycle; the discarded entries are never written.
- Idle pipeline: mc pushes x7=0xDEADBEEF at cycle 0 → rf_we_o=1, waddr=7, wdata=0xDEADBEEF at cycle 2.
- Starvation: pipeline writes every cycle; mc pushes x3=0x11 → wb_stall_o=1 exactly once after 4 waiting cycles. The x3 write precedes the stalled pipeline write, and no pipeline write is lost or duplicated.
- Full FIFO: 2 pushes while the pipeline is busy → mc_ready_o=0. A third valid is held until a pop and is then accepted, with order x5, x6, x9 preserved.
- Same-destination conflict: head x4=0xA, pipeline x4=0xB in the same cycle → 0xA written first, then 0xB; final x4=0xB.
- x0 filtering: wb_we_i with dest 0, and an mc transfer with dest 0 → rf_we_o stays 0; the mc transfer is acked and pend_cnt_o is unchanged.
